// File: rtl/tj_pkg.sv
// Shared types and default constants for the
// rare-event detector and trigger stage.
package tj_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GOT0 = 2'd1,
    GOT1 = 2'd2,
    HOLD = 2'd3
  } tj_state_t;

  localparam logic [127:0] TJ_SEQ0 =
    128'h3243F6A8885A308D313198A2E0370734;
  localparam logic [127:0] TJ_SEQ1 =
    128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] TJ_SEQ2 =
    128'h0123456789ABCDEFFEDCBA9876543210;

  localparam logic [7:0] TJ_MATCH_BYTE = 8'hA5;

endpackage

// File: rtl/tj_sat_counter.sv
// Saturating up-counter with synchronous clear
// and asynchronous active-high reset.
module tj_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] MAX = '1;

  // Count up on inc, pin at all-ones, clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tj_rare_event_detector.sv
// Watches the plaintext handshake for an arming
// sequence (r1 window) and marker bytes (r2).
module tj_rare_event_detector
  import tj_pkg::*;
#(
  parameter int              DATA_W      = 128,
  parameter logic [DATA_W-1:0] SEQ0      = TJ_SEQ0,
  parameter logic [DATA_W-1:0] SEQ1      = TJ_SEQ1,
  parameter logic [DATA_W-1:0] SEQ2      = TJ_SEQ2,
  parameter int              HOLD_CYCLES = 200,
  parameter logic [7:0]      MATCH_BYTE  = TJ_MATCH_BYTE,
  parameter int              THRESH      = 16,
  parameter int              CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              pt_valid,
  input  logic [DATA_W-1:0] pt_data,
  output logic              r1,
  output logic              r2
);

  localparam logic [7:0] HOLD_LOAD =
    8'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] THR =
    CNT_W'(THRESH);

  tj_state_t        state;
  tj_state_t        state_n;
  logic [7:0]       hold_cnt;
  logic [7:0]       hold_n;
  logic [CNT_W-1:0] match_cnt;
  logic             hit0;
  logic             hit1;
  logic             hit2;
  logic             mark;

  assign hit0 = pt_valid && (pt_data == SEQ0);
  assign hit1 = pt_valid && (pt_data == SEQ1);
  assign hit2 = pt_valid && (pt_data == SEQ2);
  assign mark = pt_valid &&
                (pt_data[7:0] == MATCH_BYTE);

  // Next-state and hold counter; clear beats input.
  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    if (clear) begin
      state_n = IDLE;
      hold_n  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hit0) state_n = GOT0;
        end
        GOT0: begin
          if (hit1)          state_n = GOT1;
          else if (hit0)     state_n = GOT0;
          else if (pt_valid) state_n = IDLE;
        end
        GOT1: begin
          if (hit2) begin
            state_n = HOLD;
            hold_n  = HOLD_LOAD;
          end else if (hit0) begin
            state_n = GOT0;
          end else if (pt_valid) begin
            state_n = IDLE;
          end
        end
        HOLD: begin
          if (hold_cnt == 8'd0) state_n = IDLE;
          else hold_n = hold_cnt - 8'd1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // FSM state, hold counter and registered r1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      r1       <= 1'b0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
      r1       <= (state_n == HOLD);
    end
  end

  tj_sat_counter #(
    .CNT_W (CNT_W)
  ) u_match (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .inc   (mark),
    .cnt   (match_cnt)
  );

  // Registered threshold flag; sticky via saturation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2 <= 1'b0;
    end else if (clear) begin
      r2 <= 1'b0;
    end else begin
      r2 <= (match_cnt >= THR);
    end
  end

endmodule

// File: tb/tb_tj_rare_event_detector.sv
// Directed self-checking bench for the
// rare-event detector.
module tb_tj_rare_event_detector;
  import tj_pkg::*;

  localparam logic [127:0] S0 = TJ_SEQ0;
  localparam logic [127:0] S1 = TJ_SEQ1;
  localparam logic [127:0] S2 = TJ_SEQ2;
  localparam logic [127:0] MK = 128'hA5;

  logic         clk;
  logic         rst;
  logic         clear;
  logic         pt_valid;
  logic [127:0] pt_data;
  logic         r1;
  logic         r2;

  int checks = 0;
  int errors = 0;

  tj_rare_event_detector dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .pt_valid (pt_valid),
    .pt_data  (pt_data),
    .r1       (r1),
    .r2       (r2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive(input logic [127:0] b);
    pt_valid = 1'b1;
    pt_data  = b;
    step();
    pt_valid = 1'b0;
    pt_data  = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Length of r1 run starting at current sample.
  task automatic pulse_len(output int len);
    len = 0;
    for (int i = 0; i < 300; i++) begin
      if (!r1) break;
      len++;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0;
    pt_valid = 1'b0; pt_data = '0;
    idle(2);
    rst = 1'b0;
    step();
    checks++;
    if (r1 !== 1'b0 || r2 !== 1'b0) begin
      errors++;
      $display("FAIL reset r1=%b r2=%b req 0 0",
               r1, r2);
    end
    checks++;
    if (dut.state !== IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d req 0",
               dut.state);
    end
  endtask

  task automatic test_basic();
    int len;
    drive(S0); drive(S1);
    checks++;
    if (r1 !== 1'b0) begin
      errors++;
      $display("FAIL basic_pre r1=%b req 0", r1);
    end
    drive(S2);
    pulse_len(len);
    checks++;
    if (len != 200) begin
      errors++;
      $display("FAIL basic_len got %0d req 200", len);
    end
    checks++;
    if (r1 !== 1'b0 || r2 !== 1'b0) begin
      errors++;
      $display("FAIL basic_end r1=%b r2=%b req 0 0",
               r1, r2);
    end
  endtask

  task automatic test_gaps();
    int len;
    drive(S0); idle(5);
    drive(S1); idle(3);
    drive(S2);
    pulse_len(len);
    checks++;
    if (len != 200) begin
      errors++;
      $display("FAIL gaps_len got %0d req 200", len);
    end
  endtask

  task automatic test_break();
    int hi;
    hi = 0;
    drive(S0); drive(S1);
    drive(128'h0); drive(S2);
    for (int i = 0; i < 5; i++) begin
      if (r1) hi++;
      step();
    end
    checks++;
    if (hi != 0) begin
      errors++;
      $display("FAIL break r1_high %0d req 0", hi);
    end
  endtask

  task automatic test_rearm();
    int len;
    drive(S0); drive(S0);
    drive(S1); drive(S2);
    pulse_len(len);
    checks++;
    if (len != 200) begin
      errors++;
      $display("FAIL rearm0 got %0d req 200", len);
    end
    drive(S0); drive(S1);
    drive(S0); drive(S1); drive(S2);
    pulse_len(len);
    checks++;
    if (len != 200) begin
      errors++;
      $display("FAIL rearm1 got %0d req 200", len);
    end
  endtask

  task automatic test_marker();
    do_clear();
    for (int i = 0; i < 15; i++) drive(MK);
    step();
    checks++;
    if (r2 !== 1'b0) begin
      errors++;
      $display("FAIL mark15 r2=%b req 0", r2);
    end
    drive(MK);
    step();
    checks++;
    if (r2 !== 1'b1) begin
      errors++;
      $display("FAIL mark16 r2=%b req 1", r2);
    end
    for (int i = 0; i < 300; i++) drive(MK);
    step();
    checks++;
    if (dut.match_cnt !== 8'd255) begin
      errors++;
      $display("FAIL mark_sat got %0d req 255",
               dut.match_cnt);
    end
    checks++;
    if (r2 !== 1'b1) begin
      errors++;
      $display("FAIL mark_sticky r2=%b req 1", r2);
    end
  endtask

  task automatic test_async_reset();
    int len;
    drive(S0); drive(S1); drive(S2);
    idle(49);
    checks++;
    if (r1 !== 1'b1 || r2 !== 1'b1) begin
      errors++;
      $display("FAIL ar_pre r1=%b r2=%b req 1 1",
               r1, r2);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (r1 !== 1'b0 || r2 !== 1'b0) begin
      errors++;
      $display("FAIL ar_now r1=%b r2=%b req 0 0",
               r1, r2);
    end
    step();
    rst = 1'b0;
    step();
    drive(S0); drive(S1); drive(S2);
    pulse_len(len);
    checks++;
    if (len != 200) begin
      errors++;
      $display("FAIL ar_retrig got %0d req 200", len);
    end
  endtask

  task automatic test_clear();
    drive(S0); drive(S1); drive(S2);
    drive(MK); drive(MK); drive(MK);
    checks++;
    if (r1 !== 1'b1 || dut.match_cnt !== 8'd3) begin
      errors++;
      $display("FAIL clr_pre r1=%b cnt=%0d req 1 3",
               r1, dut.match_cnt);
    end
    clear = 1'b1;
    pt_valid = 1'b1;
    pt_data = MK;
    step();
    clear = 1'b0;
    pt_valid = 1'b0;
    pt_data = '0;
    checks++;
    if (dut.match_cnt !== 8'd0 ||
        dut.state !== IDLE) begin
      errors++;
      $display("FAIL clr_state cnt=%0d st=%0d req 0 0",
               dut.match_cnt, dut.state);
    end
    checks++;
    if (r1 !== 1'b0 || r2 !== 1'b0) begin
      errors++;
      $display("FAIL clr_out r1=%b r2=%b req 0 0",
               r1, r2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_break();
    test_rearm();
    test_marker();
    test_async_reset();
    test_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tj_rare_event_detector.md
Name: tj_rare_event_detector

Overview:
- Upstream neighbour of the trigger counter stage; produces its two qualifying inputs, r1 and r2.
- Watches the AES plaintext input handshake for rare conditions.
- r1: asserted for a fixed window after a specific three-block plaintext sequence is seen.
- r2: sticky once enough blocks carry a marker byte. Both are clean registered levels for direct connection to the counter stage.

Parameters:
- DATA_W, 128, plaintext width.
- SEQ0, 128'h3243F6A8885A308D313198A2E0370734, first block of the arming sequence.
- SEQ1, 128'h00112233445566778899AABBCCDDEEFF, second block of the arming sequence.
- SEQ2, 128'h0123456789ABCDEFFEDCBA9876543210, third block of the arming sequence.
- HOLD_CYCLES, 200, number of cycles r1 stays high per sequence hit (1..255).
- MATCH_BYTE, 8'hA5, marker compared against plaintext[7:0].
- THRESH, 16, match count at which r2 sets (1..2^CNT_W-1).
- CNT_W, 8, match counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- clear  input  1  synchronous clear of FSM, hold counter and match counter.
- pt_valid  input  1  plaintext block presented this cycle.
- pt_data  input  DATA_W  plaintext block, sampled only when pt_valid=1.
- r1  output  1  sequence-window flag to trigger stage.
- r2  output  1  marker-threshold flag to trigger stage.

Behaviour:
- Reset (async, rst=1):
  - FSM to IDLE; hold_cnt=0; match_cnt=0; r1=0; r2=0.
  - Reset mid-HOLD drops r1 immediately, without waiting for a clock edge.
- clear=1 is synchronous. Next edge gives the same state as reset. clear has priority over pt_valid in the same cycle.
- FSM states: IDLE, GOT0, GOT1, HOLD.
  - IDLE:
    - valid and pt==SEQ0 -> GOT0.
    - Otherwise stay.
  - GOT0:
    - valid and SEQ1 -> GOT1.
    - valid and SEQ0 -> GOT0.
    - Other valid -> IDLE.
    - No valid -> stay (gaps allowed).
  - GOT1:
    - valid and SEQ2 -> HOLD; load hold_cnt=HOLD_CYCLES-1.
    - valid and SEQ0 -> GOT0.
    - Other valid -> IDLE.
    - No valid -> stay.
  - HOLD:
    - Plaintext ignored for sequence purposes.
    - hold_cnt decrements each cycle; when hold_cnt==0 -> IDLE.
- r1 is registered and equals (state==HOLD).
  - r1 rises on the edge that accepts SEQ2.
  - It stays high exactly HOLD_CYCLES cycles.
- Overlapping sequences during HOLD are not detected. After HOLD exits, detection restarts from IDLE.
- match_cnt increments on each pt_valid with pt_data[7:0]==MATCH_BYTE, in every FSM state.
  - It saturates at 2^CNT_W-1 and never wraps.
- r2 is registered and equals (match_cnt >= THRESH).
  - r2 goes high on the edge after the THRESH-th matching block is counted.
  - It stays high until rst or clear.
- A block can count toward both detectors in the same cycle.
- No combinational path from inputs to r1/r2.

Decomposition:
- Shared package tj_pkg:
  - FSM state enum (2-bit).
  - Default SEQ0/SEQ1/SEQ2 constants.
  - MATCH_BYTE default.
- One natural sub-module: tj_sat_counter (CNT_W-wide saturating up-counter with sync clear, async reset).
  - Instantiated for match_cnt.
  - Reusable by the trigger stage.
- FSM and hold counter stay in the top module.

Test Plan:
- SEQ0, SEQ1, SEQ2 on three consecutive valid cycles -> r1=1 from the edge accepting SEQ2, for exactly 200 cycles, then 0; r2 stays 0.
- SEQ0, then 5 idle cycles, then SEQ1, then 3 idle cycles, then SEQ2 -> r1 pulse of 200 cycles. SEQ0, SEQ1, 128'h0, SEQ2 -> r1 stays 0.
- SEQ0, SEQ0, SEQ1, SEQ2 -> r1 asserts (SEQ0 re-arm). SEQ0, SEQ1, SEQ0, SEQ1, SEQ2 -> r1 asserts.
- 15 valid blocks with low byte 8'hA5 -> r2=0. 16th block -> r2=1 next cycle. 300 more matches -> match_cnt holds 255, r2 stays 1.
- During HOLD (cycle 50), assert rst asynchronously -> r1=0 and r2=0 without waiting for a clock edge. After release, the full sequence re-triggers normally.
- clear and a valid 8'hA5 block in the same cycle -> match_cnt=0, state IDLE, r1=r2=0 after the edge.
